// File: rtl/cosim_event_pkg.sv
// -----------------------------------------------------------------------------
// cosim_event_pkg
// Shared types and width helpers for the cosim event timestamper.
//   cycle_t      : 64-bit unsigned cycle timebase value
//   rec_width()  : packed width of one {lost, mask, cycle} record
//   level_width(): width of an occupancy counter able to hold 0..depth
// The record layout itself is {lost, mask[mask_w-1:0], cycle[63:0]}, MSB
// first. Because the mask width is a parameter of the user module, the user
// declares the packed struct locally in that order.
// -----------------------------------------------------------------------------
package cosim_event_pkg;

   localparam int CYCLE_W = 64;

   typedef logic [CYCLE_W-1:0] cycle_t;

   function automatic int rec_width(input int mask_w);
      return 1 + mask_w + CYCLE_W;
   endfunction

   function automatic int level_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/cosim_event_timestamper_if.sv
// -----------------------------------------------------------------------------
// cosim_event_timestamper_if
// Record stream from the timestamper to the cosim host endpoint.
//   out_valid : record available           (master -> slave)
//   out_ready : consumer accepts record    (slave  -> master)
//   out_lost  : records dropped just before this one
//   out_mask  : captured event bits
//   out_cycle : cycle count at capture
// Handshake: a record transfers on a clock edge where out_valid && out_ready.
// While out_valid is high and out_ready low, all out_* hold steady, and
// out_valid only falls after a transfer (or on reset).
// -----------------------------------------------------------------------------
interface cosim_event_timestamper_if
   import cosim_event_pkg::*;
#(
   parameter int NUM_EVENTS = 4
);

   logic                  out_valid;
   logic                  out_ready;
   logic                  out_lost;
   logic [NUM_EVENTS-1:0] out_mask;
   cycle_t                out_cycle;

   modport master (
      output out_valid,
      input  out_ready,
      output out_lost,
      output out_mask,
      output out_cycle
   );

   modport slave (
      input  out_valid,
      output out_ready,
      input  out_lost,
      input  out_mask,
      input  out_cycle
   );

endinterface

// File: rtl/cosim_event_fifo.sv
// -----------------------------------------------------------------------------
// cosim_event_fifo
// Generic synchronous FIFO with register-array storage.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_data (accepted when not full, or when full and a
//                pop happens in the same cycle)
//   pop        : remove head entry (ignored when empty)
//   head_data  : oldest entry, reads 0 when empty
//   full/empty : occupancy flags
//   level      : number of stored entries, 0..DEPTH
// Pointers wrap modulo DEPTH (power of two); occupancy comes from a separate
// counter so full and empty are unambiguous without a pointer extra bit.
// -----------------------------------------------------------------------------
module cosim_event_fifo
   import cosim_event_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          push,
   input  logic [WIDTH-1:0]              push_data,
   input  logic                          pop,
   output logic [WIDTH-1:0]              head_data,
   output logic                          full,
   output logic                          empty,
   output logic [level_width(DEPTH)-1:0] level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = level_width(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic             do_push, do_pop;

   assign full    = (level_q == LW'(DEPTH));
   assign empty   = (level_q == '0);
   assign do_pop  = pop && !empty;
   // A full FIFO can take a new entry when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      level_d = level_q;
      if (do_push) wptr_d = wptr_q + AW'(1);
      if (do_pop)  rptr_d = rptr_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
      end
   end

   // Storage needs no reset: nothing is visible until level says so.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= push_data;
   end

   assign head_data = empty ? '0 : mem_q[rptr_q];
   assign level     = level_q;

endmodule

// File: rtl/cosim_event_timestamper.sv
// -----------------------------------------------------------------------------
// cosim_event_timestamper
// Samples the 64-bit cycle count whenever any enabled event line fires and
// queues {lost, mask, cycle} records for the cosim host.
//   clk, rst_n   : core clock, asynchronous active-low reset
//   cycle_count  : free-running cycle count, same clock domain
//   capture_en   : events ignored while low
//   event_i      : per-cycle event strobes
//   out_s        : record stream (valid/ready), see the interface file
//   drop_count   : saturating count of records dropped on a full FIFO
//   drop_clr     : synchronous clear of drop_count and the pending-lost flag
//   fill_level   : current FIFO occupancy
// out_s must be instantiated with the same NUM_EVENTS as this module.
// Outputs come only from registers, so event_i has no combinational path out.
// -----------------------------------------------------------------------------
module cosim_event_timestamper
   import cosim_event_pkg::*;
#(
   parameter int NUM_EVENTS = 4,
   parameter int DEPTH      = 16,
   parameter int DROP_W     = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  cycle_t                        cycle_count,
   input  logic                          capture_en,
   input  logic [NUM_EVENTS-1:0]         event_i,
   cosim_event_timestamper_if.master     out_s,
   output logic [DROP_W-1:0]             drop_count,
   input  logic                          drop_clr,
   output logic [level_width(DEPTH)-1:0] fill_level
);

   typedef struct packed {
      logic                  lost;
      logic [NUM_EVENTS-1:0] mask;
      cycle_t                cycle;
   } rec_t;

   rec_t              push_rec, head_rec;
   logic              cap, pop, push_ok, drop;
   logic              full, empty;
   logic              pending_lost_q, pending_lost_d;
   logic [DROP_W-1:0] drop_count_q, drop_count_d;

   assign cap     = capture_en && (event_i != '0);
   assign pop     = out_s.out_valid && out_s.out_ready;
   assign push_ok = cap && (!full || pop);
   assign drop    = cap && !push_ok;

   assign push_rec.lost  = pending_lost_q;
   assign push_rec.mask  = event_i;
   assign push_rec.cycle = cycle_count;

   // Drop and accepted push are mutually exclusive within a cycle, so the
   // priority between them only matters against drop_clr, which wins.
   always_comb begin
      pending_lost_d = pending_lost_q;
      drop_count_d   = drop_count_q;
      if (drop_clr) begin
         pending_lost_d = 1'b0;
         drop_count_d   = '0;
      end else if (drop) begin
         pending_lost_d = 1'b1;
         if (drop_count_q != '1) drop_count_d = drop_count_q + DROP_W'(1);
      end else if (push_ok) begin
         pending_lost_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_lost_q <= 1'b0;
         drop_count_q   <= '0;
      end else begin
         pending_lost_q <= pending_lost_d;
         drop_count_q   <= drop_count_d;
      end
   end

   cosim_event_fifo #(
      .WIDTH ($bits(rec_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_ok),
      .push_data (push_rec),
      .pop       (pop),
      .head_data (head_rec),
      .full      (full),
      .empty     (empty),
      .level     (fill_level)
   );

   // Head data is zero when empty, so the record fields read 0 after reset.
   assign out_s.out_valid = !empty;
   assign out_s.out_lost  = head_rec.lost;
   assign out_s.out_mask  = head_rec.mask;
   assign out_s.out_cycle = head_rec.cycle;
   assign drop_count      = drop_count_q;

endmodule

// File: tb/tb_cosim_event_timestamper.sv
// -----------------------------------------------------------------------------
// tb_cosim_event_timestamper
// Directed bench for cosim_event_timestamper (NUM_EVENTS=4, DEPTH=16,
// DROP_W=4 so that saturation is reachable in a short run).
// -----------------------------------------------------------------------------
module tb_cosim_event_timestamper;
   import cosim_event_pkg::*;

   localparam int NE = 4;
   localparam int DP = 16;
   localparam int DW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   cycle_t        cycle_count;
   logic          capture_en;
   logic [NE-1:0] event_i;
   logic [DW-1:0] drop_count;
   logic          drop_clr;
   logic [4:0]    fill_level;

   int n_checks = 0;
   int n_pass   = 0;

   cosim_event_timestamper_if #(.NUM_EVENTS(NE)) out_if ();

   cosim_event_timestamper #(
      .NUM_EVENTS (NE),
      .DEPTH      (DP),
      .DROP_W     (DW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cycle_count (cycle_count),
      .capture_en  (capture_en),
      .event_i     (event_i),
      .out_s       (out_if),
      .drop_count  (drop_count),
      .drop_clr    (drop_clr),
      .fill_level  (fill_level)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish, passed %0d of %0d", n_pass, n_checks);
      $fatal(1, "watchdog expired");
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   function automatic logic [71:0] rec(input logic lost, input logic [NE-1:0] mask,
                                       input cycle_t cyc);
      return {3'b000, lost, mask, cyc};
   endfunction

   function automatic logic [71:0] head();
      return {3'b000, out_if.out_lost, out_if.out_mask, out_if.out_cycle};
   endfunction

   // ---------------- drivers ----------------
   // Inputs change 1 ns after the rising edge; outputs are sampled there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fire(input cycle_t cyc, input logic [NE-1:0] ev);
      cycle_count = cyc;
      event_i     = ev;
      tick();
      event_i     = '0;
   endtask

   // Check the head record, then accept it.
   task automatic pop_check(input string tag, input logic lost, input logic [NE-1:0] mask,
                            input cycle_t cyc);
      check({tag, ".valid"}, 72'(out_if.out_valid), 72'(1));
      check({tag, ".rec"}, head(), rec(lost, mask, cyc));
      out_if.out_ready = 1'b1;
      tick();
      out_if.out_ready = 1'b0;
   endtask

   // ---------------- directed vectors ----------------
   initial begin
      rst_n            = 1'b0;
      cycle_count      = '0;
      capture_en       = 1'b0;
      event_i          = '0;
      drop_clr         = 1'b0;
      out_if.out_ready = 1'b0;
      repeat (3) tick();

      check("rst.valid", 72'(out_if.out_valid), 72'(0));
      check("rst.fill",  72'(fill_level), 72'(0));
      check("rst.drop",  72'(drop_count), 72'(0));
      check("rst.rec",   head(), 72'(0));

      rst_n      = 1'b1;
      capture_en = 1'b1;
      tick();

      // Single event, visible the cycle after capture.
      fire(64'd100, 4'b0010);
      check("single.fill", 72'(fill_level), 72'(1));
      pop_check("single", 1'b0, 4'b0010, 64'd100);
      check("single.drained", 72'(fill_level), 72'(0));

      // Multi-bit event and capture gating.
      fire(64'd200, 4'b1011);
      capture_en = 1'b0;
      fire(64'd201, 4'b1111);
      capture_en = 1'b1;
      check("gate.fill", 72'(fill_level), 72'(1));
      check("gate.drop", 72'(drop_count), 72'(0));
      pop_check("multi", 1'b0, 4'b1011, 64'd200);

      // Overflow: 20 events into 16 slots.
      for (int i = 0; i < 20; i++) fire(64'(300 + i), 4'b0001);
      check("ovf.fill", 72'(fill_level), 72'(16));
      check("ovf.drop", 72'(drop_count), 72'(4));
      for (int i = 0; i < 16; i++) pop_check("ovf.drain", 1'b0, 4'b0001, 64'(300 + i));
      check("ovf.empty", 72'(out_if.out_valid), 72'(0));
      fire(64'd400, 4'b0100);
      pop_check("lost.set", 1'b1, 4'b0100, 64'd400);
      fire(64'd401, 4'b1000);
      pop_check("lost.clr", 1'b0, 4'b1000, 64'd401);
      check("ovf.drop_keep", 72'(drop_count), 72'(4));

      drop_clr = 1'b1;
      tick();
      drop_clr = 1'b0;
      check("clr.drop", 72'(drop_count), 72'(0));

      // Full FIFO with simultaneous pop and push.
      for (int i = 0; i < 16; i++) fire(64'(480 + i), 4'b0011);
      check("fullpop.pre", 72'(fill_level), 72'(16));
      check("fullpop.head", head(), rec(1'b0, 4'b0011, 64'd480));
      out_if.out_ready = 1'b1;
      fire(64'd500, 4'b0110);
      out_if.out_ready = 1'b0;
      check("fullpop.fill", 72'(fill_level), 72'(16));
      check("fullpop.drop", 72'(drop_count), 72'(0));
      for (int i = 1; i < 16; i++) pop_check("fullpop.drain", 1'b0, 4'b0011, 64'(480 + i));
      pop_check("fullpop.last", 1'b0, 4'b0110, 64'd500);

      // Saturation of the 4-bit drop counter, then clear racing a drop.
      for (int i = 0; i < 36; i++) fire(64'(600 + i), 4'b0101);
      check("sat.fill", 72'(fill_level), 72'(16));
      check("sat.drop", 72'(drop_count), 72'(15));
      drop_clr = 1'b1;
      fire(64'd636, 4'b0101);
      drop_clr = 1'b0;
      check("satclr.drop", 72'(drop_count), 72'(0));
      for (int i = 0; i < 16; i++) pop_check("sat.drain", 1'b0, 4'b0101, 64'(600 + i));
      fire(64'd700, 4'b1001);
      pop_check("satclr.next", 1'b0, 4'b1001, 64'd700);

      // Cycle count copied verbatim across the 64-bit wrap point.
      fire(64'hFFFF_FFFF_FFFF_FFFF, 4'b0001);
      fire(64'h0, 4'b0010);
      pop_check("wrap.max",  1'b0, 4'b0001, 64'hFFFF_FFFF_FFFF_FFFF);
      pop_check("wrap.zero", 1'b0, 4'b0010, 64'h0);

      // Asynchronous reset with records queued.
      for (int i = 0; i < 5; i++) fire(64'(800 + i), 4'b0111);
      check("arst.pre", 72'(fill_level), 72'(5));
      #2;
      rst_n = 1'b0;
      #1;
      check("arst.valid", 72'(out_if.out_valid), 72'(0));
      check("arst.fill",  72'(fill_level), 72'(0));
      check("arst.rec",   head(), 72'(0));
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      fire(64'd900, 4'b1100);
      check("arst.newfill", 72'(fill_level), 72'(1));
      pop_check("arst.head", 1'b0, 4'b1100, 64'd900);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
